store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write buffer between the store-data formatter and the data-memory write port.
- Accepts lane-aligned store data, computes byte strobes from store type and address offset, and queues up to DEPTH stores.
- Drains stores in order to data memory over a valid/ready handshake.
- Flags loads whose word address matches a pending store, so the pipeline can stall until that store has drained.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- XLEN, MEM_TYPE_LEN, MEM_B, MEM_H, MEM_W: come from constants.vh, not overridable. XLEN is 32, so strobe width is 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  XLEN  byte address of the store.
- st_data  in  XLEN  store data, already masked and shifted into byte lanes.
- st_type  in  MEM_TYPE_LEN  store width: MEM_B, MEM_H or MEM_W.
- mem_valid  out  1  write request valid.
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  XLEN  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  XLEN  write data.
- mem_wstrb  out  4  byte enables.
- ld_addr  in  XLEN  load byte address to check against pending stores.
- ld_valid  in  1  ld_addr is meaningful this cycle.
- ld_hazard  out  1  a pending store targets the same word as the load.
- empty  out  1  no pending stores.
- count  out  $clog2(DEPTH+1)  number of pending stores.

Behaviour:
- Reset state: wr_ptr=0, rd_ptr=0, count=0, empty=1, st_ready=1, mem_valid=0, ld_hazard=0.
- Reset asserted mid-drain: all pending entries are discarded and the buffer returns immediately to the reset state.
- Storage: circular buffer of DEPTH entries, each holding {word_addr[XLEN-1:2], data, wstrb}.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held as a separate register.
- Push: occurs when st_valid && st_ready. st_ready = (count != DEPTH), registered-state combinational; it does not depend on mem_ready.
- Strobe generation (off = st_addr[1:0]):
  - MEM_B: 4'b0001 << off.
  - MEM_H: 4'b0011 << off, truncated to 4 bits. A misaligned halfword at off=3 therefore writes byte 3 only.
  - MEM_W: 4'b1111 regardless of off.
  - Any other st_type value: 4'b1111.
  - st_data is stored unmodified.
- Drain outputs:
  - mem_valid = !empty.
  - mem_addr, mem_wdata and mem_wstrb are driven from the entry at rd_ptr.
  - Pop occurs when mem_valid && mem_ready.
- Latency: a store pushed into an empty buffer appears on mem_* in the next cycle. There is no same-cycle bypass.
- Handshake stability: while mem_valid && !mem_ready, the mem_* outputs stay stable. mem_valid never drops without a pop.
- Simultaneous push and pop:
  - count unchanged and both pointers advance.
  - When full, st_ready is already 0, so no push can occur even if a pop happens that cycle.
  - When count=1, push and pop in the same cycle leaves count=1 and the new entry at the head.
- Order: strictly FIFO. There is no coalescing and no reordering.
- ld_hazard:
  - Combinational: ld_valid && any valid entry has word_addr == ld_addr[XLEN-1:2].
  - Strobe overlap is ignored; a word match is sufficient.
  - Entries popped in the current cycle still count toward the hazard. The store being pushed in the current cycle does not.
- empty = (count == 0).

Test Plan:
- Reset then idle → st_ready=1, mem_valid=0, empty=1, count=0. Assert reset with 3 entries pending → count=0 and mem_valid=0 with no clock edge required.
- Push SB at addr 0x1003, data 0x7700_0000, with mem_ready=1 → next cycle mem_addr=0x1000, mem_wdata=0x7700_0000, mem_wstrb=4'b1000, mem_valid=1 for exactly one cycle.
- Push SH at 0x2002 → wstrb=4'b1100. SH at 0x2003 → wstrb=4'b1000. SW at 0x2001 → wstrb=4'b1111, mem_addr=0x2000 in every case.
- Hold mem_ready=0 and push 5 stores (SW to 0x0, 0x4, 0x8, 0xC, 0x10) → first 4 accepted, st_ready=0 on the 5th, count=4. Release mem_ready → writes issue to 0x0, 0x4, 0x8, 0xC in order, all fields stable while stalled. The 5th is accepted once count<4 and issues after 0xC.
- With 3 entries pending, push and pop in the same cycle, repeated 2*DEPTH times → count stays 3, pointers wrap, and the write order equals the push order.
- Pending SW to 0x40 → ld_valid with ld_addr=0x42 gives ld_hazard=1, ld_addr=0x44 gives ld_hazard=0. After 0x40 is popped → ld_hazard=0 for 0x42. A store to 0x40 pushed in the same cycle as the check → ld_hazard=0 that cycle and 1 the next.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues lane-aligned stores with byte strobes,
// drains them in order over a valid/ready write port, and flags loads that
// hit the same word as a pending store.
module store_buffer #(
  parameter  int unsigned DEPTH        = 4,
  localparam int unsigned XLEN         = 32,
  localparam int unsigned MEM_TYPE_LEN = 2,
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [XLEN-1:0]         st_addr,
  input  logic [XLEN-1:0]         st_data,
  input  logic [MEM_TYPE_LEN-1:0] st_type,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [3:0]              mem_wstrb,
  input  logic [XLEN-1:0]         ld_addr,
  input  logic                    ld_valid,
  output logic                    ld_hazard,
  output logic                    empty,
  output logic [CNT_W-1:0]        count
);

  localparam logic [MEM_TYPE_LEN-1:0] MEM_B = 2'd0;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_H = 2'd1;
  localparam logic [MEM_TYPE_LEN-1:0] MEM_W = 2'd2;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned WA_W  = XLEN - 2;

  logic [WA_W-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rel;
  logic [3:0]       st_strb;
  logic             push;
  logic             pop;
  logic             ld_addr_unused;

  assign st_ready  = (count != CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_valid = !empty;
  assign push      = st_valid && st_ready;
  assign pop       = mem_valid && mem_ready;

  assign mem_addr  = {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = data_q[rd_ptr];
  assign mem_wstrb = strb_q[rd_ptr];

  // Only the word address of a load participates in the hazard check.
  assign ld_addr_unused = ^ld_addr[1:0];

  // Byte strobes from store width and byte offset; halfword at offset 3 truncates.
  always_comb begin
    st_strb = 4'b1111;
    case (st_type)
      MEM_B:   st_strb = 4'b0001 << st_addr[1:0];
      MEM_H:   st_strb = 4'b0011 << st_addr[1:0];
      MEM_W:   st_strb = 4'b1111;
      default: st_strb = 4'b1111;
    endcase
  end

  // Entry payload written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr[XLEN-1:2];
      data_q[wr_ptr] <= st_data;
      strb_q[wr_ptr] <= st_strb;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Word-match hazard against occupied entries; slot validity is derived from
  // its distance past rd_ptr rather than stored as a separate valid bit.
  always_comb begin
    ld_hazard = 1'b0;
    rel       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr;
      if (ld_valid && (CNT_W'(rel) < count) && (addr_q[i] == ld_addr[XLEN-1:2]))
        ld_hazard = 1'b1;
    end
  end

endmodule
